// File: rtl/mmio_decoder.sv
// rtl/mmio_decoder.sv - MMIO region decoder and request/ack transaction sequencer
// Top SEL_BITS of the address pick a slave region; unmapped regions answer with Err and are counted.
module mmio_decoder #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int SEL_BITS = 4,
    parameter int NSLV     = 3,
    parameter int WAIT     = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_req,
    input  logic [AW-1:0]        i_addr,
    input  logic [DW-1:0]        i_wdata,
    input  logic                 i_w,
    output logic                 o_busy,
    output logic                 o_ack,
    output logic                 o_err,
    output logic [DW-1:0]        o_rdata,
    output logic [NSLV-1:0]      o_sen,
    output logic [NSLV-1:0]      o_swr,
    output logic [AW-1:0]        o_saddr,
    output logic [DW-1:0]        o_swdata,
    input  logic [NSLV*DW-1:0]   i_srdata,
    output logic [7:0]           o_err_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [SEL_BITS:0] L_NSLV = (SEL_BITS+1)'(NSLV);
    localparam logic [3:0]        L_WAIT = 4'(WAIT);

    state_t                r_state;
    logic                  r_w;
    logic                  r_mapped;
    logic [SEL_BITS-1:0]   r_idx;
    logic [3:0]            r_cnt;
    logic                  r_busy;
    logic                  r_ack;
    logic                  r_err;
    logic [DW-1:0]         r_rdata;
    logic [NSLV-1:0]       r_sen;
    logic [NSLV-1:0]       r_swr;
    logic [AW-1:0]         r_saddr;
    logic [DW-1:0]         r_swdata;
    logic [7:0]            r_err_count;

    logic [SEL_BITS-1:0]   w_idx;
    logic                  w_mapped;
    logic [NSLV-1:0]       w_onehot;
    logic [DW-1:0]         w_sel_rdata;

    assign w_idx    = i_addr[AW-1 -: SEL_BITS];
    assign w_mapped = ({1'b0, w_idx} < L_NSLV);
    assign w_onehot = w_mapped ? (NSLV'(1) << w_idx) : '0;

    // Return mux over the latched region index; only consulted for mapped reads.
    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_idx == SEL_BITS'(i)) begin
                w_sel_rdata = i_srdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_w         <= 1'b0;
            r_mapped    <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_sen       <= '0;
            r_swr       <= '0;
            r_saddr     <= '0;
            r_swdata    <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (i_req) begin
                        r_saddr  <= i_addr;
                        r_swdata <= i_wdata;
                        r_w      <= i_w;
                        r_idx    <= w_idx;
                        r_mapped <= w_mapped;
                        r_sen    <= w_onehot;
                        r_swr    <= w_onehot & {NSLV{i_w}};
                        r_busy   <= 1'b1;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_sen <= '0;
                    r_swr <= '0;
                    if (r_mapped && !r_w) begin
                        r_cnt   <= L_WAIT;
                        r_state <= S_WAIT;
                    end else begin
                        r_ack   <= 1'b1;
                        r_err   <= ~r_mapped;
                        r_state <= S_RESP;
                        if (!r_mapped && !r_w) begin
                            r_rdata <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_rdata <= w_sel_rdata;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!r_mapped && r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_ack       = r_ack;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_sen       = r_sen;
    assign o_swr       = r_swr;
    assign o_saddr     = r_saddr;
    assign o_swdata    = r_swdata;
    assign o_err_count = r_err_count;

endmodule
